// File: rtl/cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : cmd_dispatcher
// Purpose  : Validates incoming command codes, queues the valid ones in a
//            small FIFO and issues them one at a time through an IDLE/RUN
//            state machine with an optional RUN-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_dispatcher #(
    parameter int DATA_W      = 8,
    parameter int OP_BASE     = 97,
    parameter int NUM_OPS     = 7,
    parameter int QUEUE_DEPTH = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             received,
    input  logic [DATA_W-1:0]                data_in,
    input  logic                             op_finished,
    input  logic                             flush,
    output logic [DATA_W-1:0]                op,
    output logic                             op_start,
    output logic                             busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count,
    output logic                             cmd_error,
    output logic                             overflow,
    output logic                             timeout
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    // Valid code window, evaluated unsigned at the command width.
    localparam logic [DATA_W-1:0] c_OP_LO    = DATA_W'(OP_BASE);
    localparam logic [DATA_W-1:0] c_OP_HI    = DATA_W'(OP_BASE + NUM_OPS - 1);
    localparam logic [CNT_W-1:0]  c_DEPTH    = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  c_PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]  c_PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [0:0]        state_q,     state_d;
    logic [DATA_W-1:0] op_q,        op_d;
    logic              op_start_q,  op_start_d;
    logic              cmd_error_q, cmd_error_d;
    logic              overflow_q,  overflow_d;
    logic              timeout_q,   timeout_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [DATA_W-1:0] mem_q [QUEUE_DEPTH];

    logic w_code_ok;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_expire;

    // Pointer advance with wrap at the last FIFO slot (depth need not be 2^n).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : (p + c_PTR_ONE);
    endfunction

    // ------------------------------------------------------------------
    // Command classification and FIFO handshake
    // ------------------------------------------------------------------
    assign w_code_ok  = (data_in >= c_OP_LO) && (data_in <= c_OP_HI);
    assign w_full     = (count_q == c_DEPTH);
    // Pops only happen from IDLE, so the edge leaving RUN never pops.
    assign w_pop      = (state_q == c_ST_IDLE) && (count_q != '0) && !flush;
    assign w_push_req = received && w_code_ok && !flush;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);

    // FIFO pointer and occupancy next-state; flush empties everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (w_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // RUN-state watchdog
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYC > 0) begin : g_wd
            localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(TIMEOUT_CYC - 1);
            localparam logic [WD_W-1:0] c_WD_ONE  = WD_W'(1);

            logic [WD_W-1:0] wd_q, wd_d;

            // Count RUN edges; restart whenever RUN is (re)entered or left.
            always_comb begin
                wd_d = '0;
                if ((state_q == c_ST_RUN) && (state_d == c_ST_RUN)) begin
                    wd_d = wd_q + c_WD_ONE;
                end
            end

            // Watchdog counter register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_q <= '0;
                end else begin
                    wd_q <= wd_d;
                end
            end

            assign w_expire = (state_q == c_ST_RUN) && (wd_q == c_WD_LAST);
        end else begin : g_no_wd
            assign w_expire = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // IDLE/RUN state machine
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_pop) begin
                    state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (flush || op_finished || w_expire) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Output next-values; op_finished wins over a watchdog expiry on the same edge.
    always_comb begin
        op_d        = op_q;
        op_start_d  = 1'b0;
        timeout_d   = 1'b0;
        cmd_error_d = received && !w_code_ok && !flush;
        overflow_d  = w_push_req && w_full && !w_pop;
        if (flush) begin
            op_d = '0;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        op_d       = mem_q[rd_ptr_q];
                        op_start_d = 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (op_finished) begin
                        op_d = '0;
                    end else if (w_expire) begin
                        op_d      = '0;
                        timeout_d = 1'b1;
                    end
                end
                default: op_d = '0;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            op_start_q  <= 1'b0;
            cmd_error_q <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            op_q        <= op_d;
            op_start_q  <= op_start_d;
            cmd_error_q <= cmd_error_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

    assign op        = op_q;
    assign op_start  = op_start_q;
    assign busy      = (state_q == c_ST_RUN);
    assign q_count   = count_q;
    assign cmd_error = cmd_error_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire
